// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxvalid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           r_state;
  logic             r_rx_m, r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rxbyte;
  logic             r_rxvalid, r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad, r_parity_err;
`endif

  assign rxbyte    = r_rxbyte;
  assign rxvalid   = r_rxvalid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rx_m      <= 1'b1;
      r_rx_s      <= 1'b1;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_rxbyte    <= '0;
      r_rxvalid   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_m      <= rx;
      r_rx_s      <= r_rx_m;
      r_rxvalid   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_END) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // a start bit that is high again at mid-bit was only a glitch
            r_state <= r_rx_s ? IDLE : DATA;
          end else r_cnt <= r_cnt + 1'b1;
        end
        DATA: begin
          if (r_cnt == BIT_END) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (r_idx == 3'd7) r_state <= PARITY;
`else
            if (r_idx == 3'd7) r_state <= STOP;
`endif
          end else r_cnt <= r_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_cnt == BIT_END) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shift, r_rx_s};
            r_state   <= STOP;
          end else r_cnt <= r_cnt + 1'b1;
        end
`endif
        STOP: begin
          if (r_cnt == BIT_END) begin
            r_cnt <= '0;
            // leaving at mid stop bit lets a back-to-back start edge be caught
            if (r_rx_s) begin
              r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) r_parity_err <= 1'b1;
              else begin
                r_rxbyte  <= r_shift;
                r_rxvalid <= 1'b1;
              end
`else
              r_rxbyte  <= r_shift;
              r_rxvalid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else r_cnt <= r_cnt + 1'b1;
        end
        BREAK: if (r_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at CLKS_PER_BIT=16: expected strobes (kind, byte, cycle) are queued at drive time.
module tb_uart_rx_8n1;
  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam int LAT = 3 + H + NBITS * C;  // start-drive edge to strobe-visible edge

  typedef struct {
    int         kind;  // 0 valid, 1 frame_err, 2 parity_err
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       hwclk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rxbyte;
  logic       rxvalid, frame_err, parity_err, busy;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
    .hwclk(hwclk), .rst(rst), .rx(rx), .rxbyte(rxbyte), .rxvalid(rxvalid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge hwclk) begin
    if (!rst && (rxvalid || frame_err || parity_err)) begin
      int k;
      k = rxvalid ? 0 : (frame_err ? 1 : 2);
      chk("exclusive", {29'd0, rxvalid, frame_err, parity_err} & (32'd7 - (32'd1 << (2 - k))), 32'd0);
      if (sb.size() == 0) chk("spurious_strobe", k, 32'hDEAD);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", k, e.kind);
        chk("cycle", cyc, e.cyc);
        chk("rxbyte", rxbyte, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  // Drives one frame; stop_v is the stop level, par_flip inverts the correct even-parity bit,
  // tail is how many cycles the stop level is held beyond the bit time.
  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip, input int tail);
    exp_t e;
    logic [9:0] bits;
    @(posedge hwclk); #1;
    e.cyc = cyc + LAT;
    e.data = last_good;
    e.kind = 0;
`ifdef UART_RX_PARITY_EN
    if (!stop_v) e.kind = 1;
    else if (par_flip) e.kind = 2;
    else begin e.data = b; last_good = b; end
`else
    if (!stop_v) e.kind = 1;
    else begin e.data = b; last_good = b; end
`endif
    sb.push_back(e);
    bits = {1'b0, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      tick(C);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    tick(C);
`endif
    rx = stop_v;
    tick(C + tail);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin tick(1); n++; end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    tick(4);
    chk("rst_rxbyte", rxbyte, 0);
    chk("rst_rxvalid", rxvalid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // 1: single good frame
    send(8'hA5, 1'b1, 1'b0, 8);
    drain("drain_a5");
    chk("a5_hold", rxbyte, 8'hA5);

    // 2: short glitch is rejected
    rx = 1'b0; tick(4); rx = 1'b1;
    tick(20);
    chk("glitch_busy", busy, 0);
    chk("glitch_rxbyte", rxbyte, 8'hA5);

    // 3: framing error with line held low, then recovery
    send(8'h3C, 1'b0, 1'b0, 40);
    drain("drain_ferr");
    tick(10);
    chk("ferr_busy", busy, 0);
    chk("ferr_rxbyte", rxbyte, 8'hA5);
    send(8'h55, 1'b1, 1'b0, 8);
    drain("drain_55");

    // 4: back-to-back frames, no idle
    send(8'h00, 1'b1, 1'b0, 0);
    send(8'hFF, 1'b1, 1'b0, 8);
    drain("drain_b2b");
    chk("b2b_rxbyte", rxbyte, 8'hFF);

    // 5: reset during bit 3 of 0x81
    @(posedge hwclk); #1;
    rx = 1'b0; tick(C);
    rx = 1'b1; tick(C);
    rx = 1'b0; tick(2 * C);
    tick(C / 2);
    rst = 1'b1; rx = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge hwclk);
    chk("mrst_busy", busy, 0);
    chk("mrst_rxbyte", rxbyte, 0);
    last_good = 8'h00;
    tick(3 * C);
    chk("mrst_idle", busy, 0);
    send(8'h12, 1'b1, 1'b0, 8);
    drain("drain_12");

`ifdef UART_RX_PARITY_EN
    // 6: parity bit wrong then right
    send(8'h07, 1'b1, 1'b1, 8);
    drain("drain_perr");
    chk("perr_rxbyte", rxbyte, 8'h12);
    send(8'h07, 1'b1, 1'b0, 8);
    drain("drain_07");
`endif

    tick(3 * C);
    chk("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end
endmodule
